// File: rtl/timer_bank.sv
// timer_bank: CHANNELS independent programmable down/up timers behind one register window.
// Defining TIMER_BANK_PRESCALE_EN adds an 8-bit per-channel prescaler in CTRL[15:8].
module timer_bank #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          addr,
  input  logic                we,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CNT = 2'd2} state_e;

  localparam logic [1:0] MODE_RELOAD = 2'b01;
  localparam logic [1:0] MODE_FREE   = 2'b10;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PRESET  = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [5:0] sel_ch;
  logic [1:0] sel_reg;
  assign sel_ch  = addr[7:2];
  assign sel_reg = addr[1:0];

  logic [WIDTH-1:0]    ctrl_rd   [CHANNELS];
  logic [WIDTH-1:0]    preset_rd [CHANNELS];
  logic [WIDTH-1:0]    count_rd  [CHANNELS];
  logic [CHANNELS-1:0] pend_rd;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           state_q, state_d;
    logic             en_q, en_d, im_q, im_d, pend_q, pend_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] preset_q, preset_d, count_q, count_d, ctrl_val;
    logic             wr_ch, wr_ctrl, wr_preset, wr_status;
    logic             en_eff, step, fire, drop_en;

    assign wr_ch     = we && (sel_ch == 6'(g));
    assign wr_ctrl   = wr_ch && (sel_reg == REG_CTRL);
    assign wr_preset = wr_ch && (sel_reg == REG_PRESET);
    assign wr_status = wr_ch && (sel_reg == REG_STATUS);
    // A CTRL write that sets EN starts LOAD on that very edge.
    assign en_eff    = wr_ctrl ? din[0] : en_q;

`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0] psc_q, psc_d, pcnt_q, pcnt_d;
    assign step = (pcnt_q == psc_q);

    always_comb begin
      psc_d  = wr_ctrl ? din[15:8] : psc_q;
      pcnt_d = '0;
      if (state_q == S_CNT && en_q && !step) pcnt_d = pcnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        psc_q  <= '0;
        pcnt_q <= '0;
      end else begin
        psc_q  <= psc_d;
        pcnt_q <= pcnt_d;
      end
    end
`else
    assign step = 1'b1;
`endif

    always_comb begin
      state_d = state_q;
      count_d = count_q;
      fire    = 1'b0;
      drop_en = 1'b0;
      case (state_q)
        S_IDLE: if (en_eff) state_d = S_LOAD;
        S_LOAD: begin
          count_d = (mode_q == MODE_FREE) ? '0 : preset_q;
          state_d = S_CNT;
        end
        S_CNT: begin
          if (!en_q) begin
            state_d = S_IDLE;
          end else if (step) begin
            if (mode_q == MODE_FREE) begin
              count_d = count_q + WIDTH'(1);
              fire    = &count_q;
            end else if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              count_d = '0;
              fire    = 1'b1;
              if (mode_q == MODE_RELOAD) begin
                state_d = S_LOAD;
              end else begin
                drop_en = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // CPU writes override the hardware EN clear; a hardware set overrides W1C.
    always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      im_d   = im_q;
      if (wr_ctrl) begin
        en_d   = din[0];
        mode_d = din[2:1];
        im_d   = din[3];
      end else if (drop_en) begin
        en_d = 1'b0;
      end
      preset_d = wr_preset ? din : preset_q;
      pend_d   = fire | (pend_q & ~(wr_status & din[0]));
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= S_IDLE;
        en_q     <= 1'b0;
        mode_q   <= '0;
        im_q     <= 1'b0;
        preset_q <= '0;
        count_q  <= '0;
        pend_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        en_q     <= en_d;
        mode_q   <= mode_d;
        im_q     <= im_d;
        preset_q <= preset_d;
        count_q  <= count_d;
        pend_q   <= pend_d;
      end
    end

    always_comb begin
      ctrl_val      = '0;
      ctrl_val[0]   = en_q;
      ctrl_val[2:1] = mode_q;
      ctrl_val[3]   = im_q;
`ifdef TIMER_BANK_PRESCALE_EN
      ctrl_val[15:8] = psc_q;
`endif
    end

    assign ctrl_rd[g]   = ctrl_val;
    assign preset_rd[g] = preset_q;
    assign count_rd[g]  = count_q;
    assign pend_rd[g]   = pend_q;
    assign irq[g]       = pend_q & im_q;
  end

  assign irq_any = |irq;

  // Unimplemented channel indices fall through to zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_ch == 6'(i)) begin
        case (sel_reg)
          REG_CTRL:   dout = ctrl_rd[i];
          REG_PRESET: dout = preset_rd[i];
          REG_COUNT:  dout = count_rd[i];
          default:    dout = {{(WIDTH-1){1'b0}}, pend_rd[i]};
        endcase
      end
    end
  end
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: vector table, directed corner sequences and a randomized run
// against a cycle-stepped model of the register/timer rules.
module tb_timer_bank;
  localparam int NCH = 2;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     addr = '0;
  logic           we = 1'b0;
  logic [W-1:0]   din = '0;
  logic [W-1:0]   dout;
  logic [NCH-1:0] irq;
  logic           irq_any;

  int errors = 0;
  int checks = 0;

  timer_bank #(.CHANNELS(NCH), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din),
    .dout(dout), .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] a, input logic [W-1:0] d);
    we = w; addr = a; din = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, 32'(dout), exp);
  endtask

  // Reference model: per-channel registers plus phase (0 idle, 1 load, 2 running).
  int m_en[NCH], m_mode[NCH], m_im[NCH], m_psc[NCH], m_tick[NCH];
  int m_pre[NCH], m_cnt[NCH], m_pend[NCH], m_ph[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0; m_tick[c] = 0;
      m_pre[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_ph[c] = 0;
    end
  endtask

  task automatic model_edge(input logic w, input logic [7:0] a, input logic [W-1:0] d);
    int ch, r, nph, ncnt;
    bit wr, fire, drop;
    ch = int'(a[7:2]);
    r  = int'(a[1:0]);
    for (int c = 0; c < NCH; c++) begin
      wr = w && (ch == c);
      nph = m_ph[c]; ncnt = m_cnt[c]; fire = 0; drop = 0;
      if (m_ph[c] == 0) begin
        m_tick[c] = 0;
        if ((wr && r == 0) ? d[0] : (m_en[c] != 0)) nph = 1;
      end else if (m_ph[c] == 1) begin
        m_tick[c] = 0;
        ncnt = (m_mode[c] == 2) ? 0 : m_pre[c];
        nph = 2;
      end else if (m_en[c] == 0) begin
        m_tick[c] = 0;
        nph = 0;
      end else if (m_tick[c] != m_psc[c]) begin
        m_tick[c]++;
      end else begin
        m_tick[c] = 0;
        if (m_mode[c] == 2) begin
          ncnt = (m_cnt[c] + 1) % (1 << W);
          fire = (ncnt == 0);
        end else if (m_cnt[c] <= 1) begin
          ncnt = 0;
          fire = 1;
          if (m_mode[c] == 1) nph = 1;
          else begin drop = 1; nph = 0; end
        end else begin
          ncnt = m_cnt[c] - 1;
        end
      end
      if (wr && r == 0) begin
        m_en[c] = int'(d[0]); m_mode[c] = int'(d[2:1]); m_im[c] = int'(d[3]);
`ifdef TIMER_BANK_PRESCALE_EN
        m_psc[c] = int'(d[15:8]);
`endif
      end else if (drop) begin
        m_en[c] = 0;
      end
      if (wr && r == 1) m_pre[c] = int'(d);
      if (wr && r == 3 && d[0]) m_pend[c] = 0;
      if (fire) m_pend[c] = 1;
      m_cnt[c] = ncnt;
      m_ph[c] = nph;
    end
  endtask

  function automatic int model_read(input logic [7:0] a);
    int ch, r;
    ch = int'(a[7:2]);
    r  = int'(a[1:0]);
    if (ch >= NCH) return 0;
    case (r)
      0: return m_en[ch] | (m_mode[ch] << 1) | (m_im[ch] << 3) | (m_psc[ch] << 8);
      1: return m_pre[ch];
      2: return m_cnt[ch];
      default: return m_pend[ch];
    endcase
  endfunction

  function automatic int model_irq();
    int v = 0;
    for (int c = 0; c < NCH; c++) if (m_pend[c] != 0 && m_im[c] != 0) v |= (1 << c);
    return v;
  endfunction

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [15:0] d;
    logic [7:0] ra;
    logic [15:0] exp_dout;
    logic [1:0] exp_irq;
  } vec_t;
  vec_t vt[$];

  task automatic addv(input logic w, input logic [7:0] a, input logic [15:0] d,
                      input logic [7:0] ra, input logic [15:0] ed, input logic [1:0] ei);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.ra = ra; v.exp_dout = ed; v.exp_irq = ei;
    vt.push_back(v);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit found;
    logic [7:0] ra;
    logic w;
    logic [7:0] a;
    logic [W-1:0] d;

    // One-shot on ch0 with IM, then W1C, invalid channel, IM=0 sticky pending.
    addv(1, 8'h01, 16'd5,      8'h01, 16'd5, 2'b00);
    addv(1, 8'h00, 16'h0009,   8'h00, 16'h9, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd5, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd4, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd3, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd2, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd1, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd0, 2'b01);
    addv(0, 8'h00, 16'h0,      8'h00, 16'h8, 2'b01);
    addv(0, 8'h00, 16'h0,      8'h03, 16'd1, 2'b01);
    addv(1, 8'h03, 16'h0,      8'h03, 16'd1, 2'b01);
    addv(1, 8'h03, 16'h1,      8'h03, 16'd0, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd0, 2'b00);
    addv(1, 8'h09, 16'h1234,   8'h09, 16'd0, 2'b00);
    addv(0, 8'h00, 16'h0,      8'hFF, 16'd0, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h01, 16'd5, 2'b00);
    addv(1, 8'h01, 16'd2,      8'h01, 16'd2, 2'b00);
    addv(1, 8'h00, 16'h0001,   8'h00, 16'h1, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd2, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h02, 16'd1, 2'b00);
    addv(0, 8'h00, 16'h0,      8'h03, 16'd1, 2'b00);
    addv(1, 8'h00, 16'h0008,   8'h00, 16'h8, 2'b01);
    addv(1, 8'h03, 16'h1,      8'h03, 16'd0, 2'b00);

    // Reset state, including edges while reset is held.
    #2;
    rdchk("rst_ctrl0", 8'h00, 0);
    rdchk("rst_pre0", 8'h01, 0);
    rdchk("rst_cnt1", 8'h06, 0);
    rdchk("rst_stat1", 8'h07, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_irq_any", 32'(irq_any), 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) begin
      we = vt[i].w; addr = vt[i].a; din = vt[i].d;
      @(posedge clk);
      #1;
      we = 1'b0;
      addr = vt[i].ra;
      #1;
      chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vt[i].exp_dout));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].exp_irq));
      chk($sformatf("vec%0d_any", i), 32'(irq_any), 32'(|vt[i].exp_irq));
    end

    // Ch1 auto-reload, PRESET=3: fires every 4 edges; W1C vs simultaneous set.
    cyc(1, 8'h05, 16'd3);
    cyc(1, 8'h04, 16'h000B);
    cyc(0, 8'h00, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    chk("ar_before_fire", 32'(irq[1]), 0);
    cyc(0, 8'h00, 0);
    chk("ar_first_fire", 32'(irq[1]), 1);
    cyc(1, 8'h07, 16'h1);
    chk("ar_w1c_clear", 32'(irq[1]), 0);
    cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    chk("ar_quiet", 32'(irq[1]), 0);
    cyc(1, 8'h07, 16'h1);
    chk("ar_set_wins", 32'(irq[1]), 1);
    cyc(1, 8'h07, 16'h1);
    chk("ar_clear2", 32'(irq[1]), 0);
    n = 0; found = 0;
    while (!found && n < 10) begin
      cyc(0, 8'h00, 0);
      n++;
      if (irq[1] === 1'b1) found = 1;
    end
    chk("ar_period_gap", 32'(n), 3);
    cyc(1, 8'h04, 16'h0);
    cyc(1, 8'h07, 16'h1);
    cyc(0, 8'h00, 0);
    chk("ar_stopped", 32'(irq), 0);

`ifndef TIMER_BANK_PRESCALE_EN
    cyc(1, 8'h04, 16'h0300);
    rdchk("ctrl_hi_ignored", 8'h04, 0);
`endif

    // Ch0 free-run wrap at 16 bits.
    cyc(1, 8'h00, 16'h000D);
    cyc(0, 8'h02, 0);
    chk("fr_start", 32'(dout), 0);
    repeat (65535) cyc(0, 8'h02, 0);
    chk("fr_allones", 32'(dout), 32'hFFFF);
    chk("fr_no_irq_yet", 32'(irq[0]), 0);
    cyc(0, 8'h02, 0);
    chk("fr_wrap_cnt", 32'(dout), 0);
    chk("fr_wrap_irq", 32'(irq[0]), 1);
    cyc(1, 8'h00, 16'h0);
    cyc(1, 8'h03, 16'h1);

    // Asynchronous reset between edges while counting with a pending irq.
    cyc(1, 8'h05, 16'd1);
    cyc(1, 8'h04, 16'h0009);
    cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    chk("ar_pre_rst_irq", 32'(irq), 32'h2);
    cyc(1, 8'h01, 16'd20);
    cyc(1, 8'h00, 16'h0009);
    cyc(0, 8'h02, 0); cyc(0, 8'h02, 0); cyc(0, 8'h02, 0);
    chk("pre_rst_cnt", 32'(dout), 18);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_irq", 32'(irq), 0);
    chk("arst_any", 32'(irq_any), 0);
    chk("arst_cnt", 32'(dout), 0);
    rdchk("arst_ctrl", 8'h00, 0);
    rdchk("arst_pre", 8'h01, 0);
    rdchk("arst_stat1", 8'h07, 0);
    rdchk("arst_badch", 8'h08, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      w = ($urandom_range(0, 2) == 0);
      a = {6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d = (a[1:0] == 2'd1) ? W'($urandom_range(0, 6)) : W'($urandom & 32'h03FF);
      model_edge(w, a, d);
      cyc(w, a, d);
      ra = {6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      addr = ra;
      #1;
      chk($sformatf("rnd%0d_dout@%0h", i, ra), 32'(dout), 32'(model_read(ra)));
      chk($sformatf("rnd%0d_irq", i), 32'(irq), 32'(model_irq()));
      chk($sformatf("rnd%0d_any", i), 32'(irq_any), 32'(model_irq() != 0));
    end

`ifdef TIMER_BANK_PRESCALE_EN
    // Prescale P=3: steps every 4 cycles, one-shot fires after k+9.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cyc(1, 8'h01, 16'd2);
    cyc(1, 8'h00, 16'h0309);
    repeat (4) cyc(0, 8'h02, 0);
    chk("psc_k4_cnt", 32'(dout), 2);
    cyc(0, 8'h02, 0);
    chk("psc_k5_cnt", 32'(dout), 1);
    repeat (3) cyc(0, 8'h02, 0);
    chk("psc_k8_irq", 32'(irq[0]), 0);
    cyc(0, 8'h02, 0);
    chk("psc_k9_irq", 32'(irq[0]), 1);
    rdchk("psc_ctrl", 8'h00, 32'h0308);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
